// File: rtl/serial_mult_pkg.sv
// -----------------------------------------------------------------------------
// serial_mult_pkg
// Shared definitions for the serial shift-add multiplier:
//   state_e    - controller state encoding (IDLE/RUN/DONE)
//   cnt_width  - width of the bit counter, large enough to hold WIDTH
// -----------------------------------------------------------------------------
package serial_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_mult_param_if.sv
// -----------------------------------------------------------------------------
// serial_mult_param_if
// Handshake/data bundle for serial_mult_param.
//   start   : request to begin a multiply
//   a, b    : multiplicand / multiplier (WIDTH bits)
//   ready   : multiplier idle, start will be accepted
//   busy    : multiply in progress
//   done    : one-cycle pulse, product holds a new result
//   product : last completed result (2*WIDTH bits)
// master = requester side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface serial_mult_param_if #(
  parameter int WIDTH = 16
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );

endinterface

// File: rtl/serial_mult_dp.sv
// -----------------------------------------------------------------------------
// serial_mult_dp
// Shift-add datapath: operand latches, 2*WIDTH accumulator, product register.
// Optional macro: SERIAL_MULT_SIGNED_EN - latch operand magnitudes and the
// result sign, negate the result when it is loaded into product.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load_i      : latch a_i/b_i, clear accumulator
//   step_i      : process one multiplier bit (LSB first)
//   finish_i    : last step; load product from the final sum
//   a_i, b_i    : operands
//   product_o   : registered result
// -----------------------------------------------------------------------------
module serial_mult_dp
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 finish_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SERIAL_MULT_SIGNED_EN
  logic neg_q, neg_d;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct
  // magnitude, so no extra operand bit is needed.
  assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
  assign result = neg_q ? -acc_sum : acc_sum;
`else
  assign a_mag  = a_i;
  assign b_mag  = b_i;
  assign result = acc_sum;
`endif

  // The multiplicand is pre-shifted each step, so the add is always aligned.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
`ifdef SERIAL_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
`ifdef SERIAL_MULT_SIGNED_EN
      neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`endif
    end else if (step_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (finish_i) begin
        prod_d = result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
`ifdef SERIAL_MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
`ifdef SERIAL_MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/serial_mult_param.sv
// -----------------------------------------------------------------------------
// serial_mult_param
// Serial shift-add multiplier, one multiplier bit per clock.
// Latency WIDTH+1 edges from accepting start to done; one result per WIDTH+2
// cycles back to back.
// Optional macro: SERIAL_MULT_SIGNED_EN (two's complement operands/result,
// handled inside serial_mult_dp).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : async active-low reset
//   sm     : serial_mult_param_if.slave (start/a/b in, ready/busy/done/product out)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting; ready=1, start accepted
// RUN   | one shift-add step per clock, counter counts down
// DONE  | product valid, done pulses for this one cycle
// -----------------------------------------------------------------------------
module serial_mult_param
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_mult_param_if.slave   sm
);

  localparam int CW = cnt_width(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step, finish;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sm.start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          load    = 1'b1;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        // Counter reaching zero on this edge: last bit, hand off to DONE.
        if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_i    (step),
    .finish_i  (finish),
    .a_i       (sm.a),
    .b_i       (sm.b),
    .product_o (sm.product)
  );

  assign sm.ready = (state_q == IDLE);
  assign sm.busy  = (state_q == RUN);
  assign sm.done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_mult_param.sv
// -----------------------------------------------------------------------------
// tb_serial_mult_param
// Three multiplier instances (WIDTH 4, 16, 32) sharing clock and reset,
// driven one at a time and compared against an arithmetic reference model.
// Compile with SERIAL_MULT_SIGNED_EN to exercise the signed build.
// -----------------------------------------------------------------------------
module tb_serial_mult_param;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [63:0] prev_prod [3];

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  serial_mult_param_if #(.WIDTH(4))  b4  ();
  serial_mult_param_if #(.WIDTH(16)) b16 ();
  serial_mult_param_if #(.WIDTH(32)) b32 ();

  serial_mult_param #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .sm(b4));
  serial_mult_param #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .sm(b16));
  serial_mult_param #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .sm(b32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer multiply of the operands as the build interprets them.
  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, pm, ua, ub;
`ifdef SERIAL_MULT_SIGNED_EN
    longint sa, sb;
`endif
    m  = (64'd1 << w) - 64'd1;
    pm = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ua = a & m;
    ub = b & m;
`ifdef SERIAL_MULT_SIGNED_EN
    sa = ua[w-1] ? longint'(ua | ~m) : longint'(ua);
    sb = ub[w-1] ? longint'(ub | ~m) : longint'(ub);
    return 64'(sa * sb) & pm;
`else
    return (ua * ub) & pm;
`endif
  endfunction

  function automatic int idx(input int w);
    return (w == 4) ? 0 : ((w == 16) ? 1 : 2);
  endfunction

  function automatic bit f_ready(input int w);
    case (w)
      4:       return b4.ready;
      16:      return b16.ready;
      default: return b32.ready;
    endcase
  endfunction

  function automatic bit f_busy(input int w);
    case (w)
      4:       return b4.busy;
      16:      return b16.busy;
      default: return b32.busy;
    endcase
  endfunction

  function automatic bit f_done(input int w);
    case (w)
      4:       return b4.done;
      16:      return b16.done;
      default: return b32.done;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    case (w)
      4:       return 64'(b4.product);
      16:      return 64'(b16.product);
      default: return b32.product;
    endcase
  endfunction

  task automatic set_in(input int w, input bit s, input logic [63:0] a, input logic [63:0] b);
    case (w)
      4:       begin b4.start  = s; b4.a  = a[3:0];  b4.b  = b[3:0];  end
      16:      begin b16.start = s; b16.a = a[15:0]; b16.b = b[15:0]; end
      default: begin b32.start = s; b32.a = a[31:0]; b32.b = b[31:0]; end
    endcase
  endtask

  // Called on the edge that accepted start; returns at the negedge after done.
  task automatic run_to_done(input int w, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp, input bit hold, input logic [63:0] a_mid);
    int k;
    int busy_n;
    bit hold_ok;
    bit seen;
    k = 1; busy_n = 0; hold_ok = 1'b1; seen = 1'b0;
    while (k < 200 && !seen) begin
      @(negedge clk);
      if (k == 1) set_in(w, hold, hold ? a_mid : a, b);
      if (f_done(w)) seen = 1'b1;
      else begin
        if (f_busy(w)) busy_n++;
        if (get_prod(w) !== prev_prod[idx(w)]) hold_ok = 1'b0;
        @(posedge clk);
        k++;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(k), 64'(w + 1));
    check("busy_cycles", 64'(busy_n), 64'(w));
    check("prod_hold", 64'(hold_ok), 64'd1);
    check("product", get_prod(w), exp);
    prev_prod[idx(w)] = exp;
    @(negedge clk);
    check("done_one_cycle", 64'(f_done(w)), 64'd0);
    check("ready_back", 64'(f_ready(w)), 64'd1);
  endtask

  task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                       input bit hold, input logic [63:0] a_mid, output int acc_cyc);
    int t;
    t = 0;
    while (!f_ready(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 64'(f_ready(w)), 64'd1);
    set_in(w, 1'b1, a, b);
    @(posedge clk);
    acc_cyc = cyc;
    run_to_done(w, a, b, ref_mul(w, a, b), hold, a_mid);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    int ws [3];
    bit seen;
    logic [63:0] ra, rb;
    ws = '{4, 16, 32};
    for (int i = 0; i < 3; i++) prev_prod[i] = '0;

    rst_n = 1'b0;
    set_in(4, 0, 0, 0);
    set_in(16, 0, 0, 0);
    set_in(32, 0, 0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 64'(f_ready(ws[i])), 64'd1);
      check("rst_busy", 64'(f_busy(ws[i])), 64'd0);
      check("rst_done", 64'(f_done(ws[i])), 64'd0);
      check("rst_product", get_prod(ws[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

`ifndef SERIAL_MULT_SIGNED_EN
    do_op(16, 64'hFFFF, 64'hFFFF, 0, 0, c0);
    check("ffff_sq", get_prod(16), 64'hFFFE0001);
    do_op(16, 64'h0, 64'h1234, 0, 0, c0);
    check("zero_mul", get_prod(16), 64'h0);
    do_op(16, 64'h3, 64'h5, 0, 0, c1);
    check("three_five", get_prod(16), 64'hF);
    check("b2b_thruput", 64'(c1 - c0), 64'd18);
`else
    do_op(16, 64'hFFFF, 64'hFFFF, 0, 0, c0);
    check("s_m1_m1", get_prod(16), 64'h00000001);
    do_op(16, 64'h8000, 64'h8000, 0, 0, c0);
    check("s_min_min", get_prod(16), 64'h40000000);
    do_op(16, 64'h8000, 64'h0001, 0, 0, c0);
    check("s_min_one", get_prod(16), 64'hFFFF8000);
    do_op(4, 64'h8, 64'h8, 0, 0, c0);
    check("s4_min_min", get_prod(4), 64'h40);
`endif

    // start held through RUN with a changed mid-operation
    do_op(16, 64'h1234, 64'h0011, 1, 64'h0F0F, c0);
    do_op(16, 64'h0F0F, 64'h0011, 0, 0, c1);
    check("hold_thruput", 64'(c1 - c0), 64'd18);

    // reset in the middle of RUN
    set_in(16, 1, 64'hFFFF, 64'hFFFF);
    @(posedge clk);
    @(negedge clk);
    set_in(16, 0, 64'hFFFF, 64'hFFFF);
    repeat (7) @(negedge clk);
    check("mid_busy", 64'(f_busy(16)), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ready", 64'(f_ready(16)), 64'd1);
    check("mrst_busy", 64'(f_busy(16)), 64'd0);
    check("mrst_done", 64'(f_done(16)), 64'd0);
    check("mrst_product", get_prod(16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (f_done(16)) seen = 1'b1;
    end
    check("mrst_no_done", 64'(seen), 64'd0);
    check("mrst_prod_zero", get_prod(16), 64'd0);
    for (int i = 0; i < 3; i++) prev_prod[i] = '0;

    // start present while reset is low is ignored, accepted once released
    rst_n = 1'b0;
    set_in(4, 1, 64'h3, 64'h3);
    @(posedge clk);
    @(negedge clk);
    check("rst_start_ign", 64'(f_busy(4)), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    run_to_done(4, 64'h3, 64'h3, ref_mul(4, 64'h3, 64'h3), 0, 0);
    check("rst_start_acc", get_prod(4), 64'h9);

    // WIDTH=4 exhaustive
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_op(4, 64'(i), 64'(j), 0, 0, c0);
      end
    end

    // WIDTH=32 corners: all-ones, single bits, min value
    do_op(32, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 0, c0);
    do_op(32, 64'h80000000, 64'h80000000, 0, 0, c0);
    do_op(32, 64'h80000000, 64'h1, 0, 0, c0);
    do_op(32, 64'h1, 64'hFFFFFFFF, 0, 0, c0);
    for (int i = 0; i < 32; i += 5) begin
      do_op(32, 64'd1 << i, 64'd1 << (31 - i), 0, 0, c0);
    end

    for (int n = 0; n < 30; n++) begin
      ra = 64'($urandom());
      rb = 64'($urandom());
      do_op(32, ra, rb, 0, 0, c0);
      ra = 64'($urandom_range(0, 65535));
      rb = 64'($urandom_range(0, 65535));
      do_op(16, ra, rb, 0, 0, c0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
